// File: rtl/dmem_arbiter.sv
// Round-robin two-port front end for a single-port, byte-write-enabled data memory.
// Handles lane steering for stores, load extension, and misaligned/illegal access flagging.
module dmem_arbiter #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [1:0]    p0_size,
    input  logic          p0_uns,
    input  logic [AW-1:0] p0_addr,
    input  logic [31:0]   p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic          p0_err,
    output logic [31:0]   p0_rdata,

    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [1:0]    p1_size,
    input  logic          p1_uns,
    input  logic [AW-1:0] p1_addr,
    input  logic [31:0]   p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic          p1_err,
    output logic [31:0]   p1_rdata,

    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_din,
    output logic [3:0]    mem_we,
    input  logic [31:0]   mem_dout
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic          last_q;
    logic          any_gnt;

    logic          w_we;
    logic [1:0]    w_size;
    logic          w_uns;
    logic [AW-1:0] w_addr;
    logic [31:0]   w_wdata;
    logic          w_err;

    logic          r_port;
    logic          r_we;
    logic [1:0]    r_size;
    logic          r_uns;
    logic [1:0]    r_lo;
    logic          r_err;

    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [31:0]   fmt_data;

    // last_q = 1 means port 1 was granted most recently, so port 0 wins a tie.
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (rst_n && state_q == S_IDLE) begin
            if (p0_req && (!p1_req || last_q)) begin
                p0_gnt = 1'b1;
            end else if (p1_req) begin
                p1_gnt = 1'b1;
            end
        end
    end

    assign any_gnt = p0_gnt | p1_gnt;

    always_comb begin
        w_we    = p1_gnt ? p1_we    : p0_we;
        w_size  = p1_gnt ? p1_size  : p0_size;
        w_uns   = p1_gnt ? p1_uns   : p0_uns;
        w_addr  = p1_gnt ? p1_addr  : p0_addr;
        w_wdata = p1_gnt ? p1_wdata : p0_wdata;
    end

    always_comb begin
        w_err = 1'b0;
        case (w_size)
            2'b00:   w_err = 1'b0;
            2'b01:   w_err = w_addr[0];
            2'b10:   w_err = (w_addr[1:0] != 2'b00);
            default: w_err = 1'b1;
        endcase
    end

    always_comb begin
        mem_addr = '0;
        mem_din  = '0;
        mem_we   = '0;
        if (any_gnt) begin
            mem_addr = w_addr;
            case (w_size)
                2'b00:   mem_din = {4{w_wdata[7:0]}};
                2'b01:   mem_din = {2{w_wdata[15:0]}};
                default: mem_din = w_wdata;
            endcase
            if (w_we && !w_err) begin
                case (w_size)
                    2'b00:   mem_we = 4'b0001 << w_addr[1:0];
                    2'b01:   mem_we = w_addr[1] ? 4'b1100 : 4'b0011;
                    default: mem_we = 4'b1111;
                endcase
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_gnt) state_d = S_WAIT;
            S_WAIT:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            r_port  <= 1'b0;
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_lo    <= 2'b00;
            r_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (any_gnt) begin
                last_q <= p1_gnt;
                r_port <= p1_gnt;
                r_we   <= w_we;
                r_size <= w_size;
                r_uns  <= w_uns;
                r_lo   <= w_addr[1:0];
                r_err  <= w_err;
            end
        end
    end

    always_comb begin
        lane_b   = '0;
        fmt_data = '0;
        case (r_lo)
            2'd0:    lane_b = mem_dout[7:0];
            2'd1:    lane_b = mem_dout[15:8];
            2'd2:    lane_b = mem_dout[23:16];
            default: lane_b = mem_dout[31:24];
        endcase
        lane_h = r_lo[1] ? mem_dout[31:16] : mem_dout[15:0];
        case (r_size)
            2'b00:   fmt_data = r_uns ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   fmt_data = r_uns ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: fmt_data = mem_dout;
        endcase
        if (r_we || r_err) begin
            fmt_data = '0;
        end
    end

    // Completion registers hold rdata/err until the owning port's next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_rvalid <= 1'b0;
            p0_err    <= 1'b0;
            p0_rdata  <= '0;
            p1_rvalid <= 1'b0;
            p1_err    <= 1'b0;
            p1_rdata  <= '0;
        end else begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            if (state_q == S_WAIT) begin
                if (r_port) begin
                    p1_rvalid <= 1'b1;
                    p1_rdata  <= fmt_data;
                    p1_err    <= r_err;
                end else begin
                    p0_rvalid <= 1'b1;
                    p0_rdata  <= fmt_data;
                    p0_err    <= r_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a byte-array memory model predicts every grant,
// lane enable and completion; a monitor checks DUT outputs against queued expectations.
module tb_dmem_arbiter;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p0_req, p0_we, p0_uns, p0_gnt, p0_rvalid, p0_err;
    logic [1:0]    p0_size;
    logic [AW-1:0] p0_addr;
    logic [31:0]   p0_wdata, p0_rdata;
    logic          p1_req, p1_we, p1_uns, p1_gnt, p1_rvalid, p1_err;
    logic [1:0]    p1_size;
    logic [AW-1:0] p1_addr;
    logic [31:0]   p1_wdata, p1_rdata;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din, mem_dout;
    logic [3:0]    mem_we;

    dmem_arbiter #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_uns(p0_uns),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt),
        .p0_rvalid(p0_rvalid), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_uns(p1_uns),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_gnt(p1_gnt),
        .p1_rvalid(p1_rvalid), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        if (i == 1) return 32'h1122_3344;
        if (i == 2) return 32'h80F0_7F81;
        return (32'(i) * 32'h0101_0101) ^ 32'h5A3C_96E1;
    endfunction

    // Environment memory: 16 words, 1-cycle synchronous read, byte write enables.
    logic [31:0] ram [16];
    bit          mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 16; i++) ram[i] <= init_word(i);
            mem_init <= 1'b1;
        end else begin
            for (int k = 0; k < 4; k++)
                if (mem_we[k]) ram[mem_addr[5:2]][8*k +: 8] <= mem_din[8*k +: 8];
        end
        mem_dout <= ram[mem_addr[5:2]];
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned cyc;
    } exp_t;

    int           tests = 0;
    int           fails = 0;
    exp_t         q0[$];
    exp_t         q1[$];
    int           gnt_log[$];
    bit           log_en = 1'b0;
    byte unsigned refm [64];
    bit           m_busy;
    bit           m_last;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic check_cpl(input int p, input logic rv, input logic [31:0] rd, input logic er);
        exp_t e;
        if (rv !== 1'b1) return;
        tests++;
        if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
            fails++;
            $display("FAIL unexpected_rvalid_p%0d: rvalid=1, expected 0 (no access outstanding)", p);
            return;
        end
        if (p == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        if (rd !== e.rdata || er !== e.err || cyc != e.cyc + 2) begin
            fails++;
            $display("FAIL cpl_p%0d: rdata=0x%08h err=%b cycle=%0d, expected rdata=0x%08h err=%b cycle=%0d",
                     p, rd, er, cyc, e.rdata, e.err, e.cyc + 2);
        end
    endtask

    // Reference: an access touches nb consecutive bytes starting at addr.
    task automatic model_issue(input int p, input logic we, input logic [1:0] sz, input logic uns,
                               input logic [AW-1:0] addr, input logic [31:0] wd);
        int unsigned a, nb, lane;
        logic        err;
        logic [3:0]  ewe;
        logic [31:0] val;
        bit          din_ok;
        exp_t        e;
        a      = 32'(addr[5:0]);
        nb     = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        err    = (sz == 2'd3) || (a % nb != 0);
        lane   = a % 4;
        ewe    = '0;
        val    = '0;
        din_ok = 1'b1;
        if (!err && we) begin
            for (int unsigned k = 0; k < nb; k++) begin
                ewe[lane + k] = 1'b1;
                if (mem_din[8*(lane + k) +: 8] !== wd[8*k +: 8]) din_ok = 1'b0;
                refm[a + k] = wd[8*k +: 8];
            end
        end
        if (!err && !we) begin
            for (int unsigned k = 0; k < nb; k++) val = val | (32'(refm[a + k]) << (8*k));
            if (!uns && nb < 4 && val[8*nb - 1]) val = val | (32'hFFFF_FFFF << (8*nb));
        end
        tests++;
        if (mem_we !== ewe || mem_addr !== addr || !din_ok) begin
            fails++;
            $display("FAIL issue_p%0d: mem_we=%b mem_addr=0x%08h mem_din=0x%08h, expected mem_we=%b mem_addr=0x%08h lanes of 0x%08h",
                     p, mem_we, mem_addr, mem_din, ewe, addr, wd);
        end
        e.rdata = val;
        e.err   = err;
        e.cyc   = cyc;
        if (p == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic monitor();
        int eg;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                tests++;
                if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0 || mem_we !== 4'b0 ||
                    p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin
                    fails++;
                    $display("FAIL reset_quiet: gnt=%b%b mem_we=%b rvalid=%b%b, expected all 0",
                             p1_gnt, p0_gnt, mem_we, p1_rvalid, p0_rvalid);
                end
                q0.delete();
                q1.delete();
                m_busy = 1'b0;
                m_last = 1'b1;
            end else begin
                check_cpl(0, p0_rvalid, p0_rdata, p0_err);
                check_cpl(1, p1_rvalid, p1_rdata, p1_err);
                eg = -1;
                if (m_busy)                 m_busy = 1'b0;
                else if (p0_req && p1_req)  eg = m_last ? 0 : 1;
                else if (p0_req)            eg = 0;
                else if (p1_req)            eg = 1;
                tests++;
                if (p0_gnt !== (eg == 0) || p1_gnt !== (eg == 1)) begin
                    fails++;
                    $display("FAIL arb: gnt p1p0=%b%b, expected winner %0d (-1 = none)", p1_gnt, p0_gnt, eg);
                end
                if (eg == 0) begin
                    model_issue(0, p0_we, p0_size, p0_uns, p0_addr, p0_wdata);
                end else if (eg == 1) begin
                    model_issue(1, p1_we, p1_size, p1_uns, p1_addr, p1_wdata);
                end else begin
                    tests++;
                    if (mem_we !== 4'b0) begin
                        fails++;
                        $display("FAIL idle_mem_we: mem_we=%b, expected 0000", mem_we);
                    end
                end
                if (eg >= 0) begin
                    m_last = (eg == 1);
                    m_busy = 1'b1;
                    if (log_en) gnt_log.push_back(eg);
                end
            end
        end
    endtask

    // Callers enter and leave these tasks 1 time unit after a rising edge.
    task automatic do_req(input int p, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [3:0] gwe, output logic [31:0] gdin, output bit ok);
        gwe  = '0;
        gdin = '0;
        ok   = 1'b0;
        if (p == 0) begin
            p0_we = we; p0_size = sz; p0_uns = uns; p0_addr = addr; p0_wdata = wd; p0_req = 1'b1;
        end else begin
            p1_we = we; p1_size = sz; p1_uns = uns; p1_addr = addr; p1_wdata = wd; p1_req = 1'b1;
        end
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if ((p == 0 && p0_gnt === 1'b1) || (p == 1 && p1_gnt === 1'b1)) begin
                ok   = 1'b1;
                gwe  = mem_we;
                gdin = mem_din;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL gnt_timeout_p%0d: no grant within 64 cycles, expected a grant", p);
        end
        @(posedge clk);
        #1;
        if (p == 0) p0_req = 1'b0;
        else        p1_req = 1'b0;
    endtask

    task automatic wait_cpl(input int p, output logic [31:0] rd, output logic er);
        bit got;
        got = 1'b0;
        rd  = '0;
        er  = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (p == 0 && p0_rvalid === 1'b1) begin got = 1'b1; rd = p0_rdata; er = p0_err; end
            if (p == 1 && p1_rvalid === 1'b1) begin got = 1'b1; rd = p1_rdata; er = p1_err; end
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL rvalid_timeout_p%0d: no rvalid within 10 cycles, expected one", p);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rr_port(input int p);
        logic [3:0]  w;
        logic [31:0] d;
        bit          ok;
        for (int i = 0; i < 3; i++)
            do_req(p, 1'b0, 2'd2, 1'b0, 32'(4 * (i + 4 * p)), '0, w, d, ok);
    endtask

    task automatic rand_port(input int p, input int n);
        logic [3:0]  w;
        logic [31:0] d;
        bit          ok;
        logic [1:0]  sz;
        logic [31:0] a;
        int unsigned r;
        for (int t = 0; t < n; t++) begin
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            a  = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a = a & ~32'd1;
                if (sz == 2'd2) a = a & ~32'd3;
            end
            do_req(p, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, w, d, ok);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  w;
        logic [31:0] d, rd;
        logic        er;
        bit          ok;
        int          cnt;

        for (int i = 0; i < 16; i++)
            for (int k = 0; k < 4; k++) refm[4*i + k] = init_word(i) >> (8*k);
        m_busy = 1'b0;
        m_last = 1'b1;
        rst_n  = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_size = 2'd0; p0_uns = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_size = 2'd0; p1_uns = 1'b0; p1_addr = '0; p1_wdata = '0;
        fork
            monitor();
        join_none

        // Reset holds off a pending word store.
        p0_we = 1'b1; p0_size = 2'd2; p0_addr = 32'h10; p0_wdata = 32'hCAFE_F00D; p0_req = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst_p0_gnt", 32'(p0_gnt), 32'd0);
            check("rst_mem_we", 32'(mem_we), 32'd0);
            check("rst_p0_rdata", p0_rdata, 32'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("first_gnt_after_reset", 32'(p0_gnt), 32'd1);
        @(posedge clk);
        #1 p0_req = 1'b0;
        wait_cpl(0, rd, er);
        check("first_store_err", 32'(er), 32'd0);

        // Byte store then word load of the same word.
        do_req(0, 1'b1, 2'd0, 1'b0, 32'h6, 32'h0000_00AB, w, d, ok);
        check("sb_mem_we", 32'(w), 32'b0100);
        check("sb_mem_din", d, 32'hABAB_ABAB);
        wait_cpl(0, rd, er);
        do_req(0, 1'b0, 2'd2, 1'b0, 32'h4, '0, w, d, ok);
        wait_cpl(0, rd, er);
        check("lw_after_sb", rd, 32'h11AB_3344);
        @(negedge clk);
        check("rdata_hold", p0_rdata, 32'h11AB_3344);
        @(posedge clk);
        #1;

        do_req(0, 1'b0, 2'd0, 1'b0, 32'h8, '0, w, d, ok);
        wait_cpl(0, rd, er);
        check("lb_signed", rd, 32'hFFFF_FF81);
        do_req(0, 1'b0, 2'd1, 1'b1, 32'hA, '0, w, d, ok);
        wait_cpl(0, rd, er);
        check("lhu", rd, 32'h0000_80F0);
        do_req(0, 1'b0, 2'd1, 1'b0, 32'hA, '0, w, d, ok);
        wait_cpl(0, rd, er);
        check("lh_signed", rd, 32'hFFFF_80F0);

        // Misaligned word store and illegal size must leave memory untouched.
        do_req(0, 1'b1, 2'd2, 1'b0, 32'h2, 32'hDEAD_BEEF, w, d, ok);
        check("misal_mem_we", 32'(w), 32'd0);
        wait_cpl(0, rd, er);
        check("misal_err", 32'(er), 32'd1);
        check("misal_rdata", rd, 32'd0);
        do_req(0, 1'b1, 2'd3, 1'b0, 32'h0, 32'hDEAD_BEEF, w, d, ok);
        check("size11_mem_we", 32'(w), 32'd0);
        wait_cpl(0, rd, er);
        check("size11_err", 32'(er), 32'd1);
        check("size11_rdata", rd, 32'd0);
        do_req(0, 1'b0, 2'd2, 1'b0, 32'h0, '0, w, d, ok);
        wait_cpl(0, rd, er);
        check("mem_unchanged", rd, init_word(0));
        check("aligned_load_err", 32'(er), 32'd0);

        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            do_req(1, 1'b0, 2'd2, 1'b0, 32'(4 * i), '0, w, d, ok);
            if (ok) cnt++;
        end
        check("p1_alone_grants", 32'(cnt), 32'd3);
        repeat (3) @(posedge clk);
        #1;

        gnt_log.delete();
        log_en = 1'b1;
        fork
            rr_port(0);
            rr_port(1);
        join
        log_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rr_len", 32'(gnt_log.size()), 32'd6);
        for (int i = 0; i < gnt_log.size() && i < 6; i++)
            check($sformatf("rr_order_%0d", i), 32'(gnt_log[i]), 32'(i % 2));

        // Reset during WAIT of a load aborts it.
        do_req(0, 1'b0, 2'd2, 1'b0, 32'h8, '0, w, d, ok);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (p0_rvalid === 1'b1 || p1_rvalid === 1'b1) cnt++;
        end
        check("rst_abort_no_rvalid", 32'(cnt), 32'd0);
        @(posedge clk);
        #1;
        do_req(0, 1'b0, 2'd0, 1'b0, 32'h8, '0, w, d, ok);
        wait_cpl(0, rd, er);
        check("after_rst_lb", rd, 32'hFFFF_FF81);

        fork
            rand_port(0, 40);
            rand_port(1, 40);
        join
        repeat (6) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
